// File: rtl/prng_checker_pkg.sv
// Shared definitions for the PRNG bit-stream checker and its matching generator.
`timescale 1ns/1ps
package prng_checker_pkg;

    // Default LFSR shape; the generator uses the same constants so both ends stay matched.
    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_TAPS  = 8'b1011_1000;   // x^8+x^6+x^5+x^4+1

    // Checker state encoding.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/prng_lfsr_predict.sv
// History register of received bits plus tap-XOR prediction of the next bit.
`timescale 1ns/1ps
module prng_lfsr_predict
    import prng_checker_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic [WIDTH-1:0] sr,
    output logic             pred
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Shift each valid bit in at the low end; sr[0] is always the newest bit.
    always_comb begin
        sr_d = sr_q;
        if (bit_vld) begin
            sr_d = {sr_q[WIDTH-2:0], bit_in};
        end
    end

    // History register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr   = sr_q;
    assign pred = ^(sr_q & TAPS);

endmodule

// File: rtl/prng_checker.sv
// Self-synchronising PRNG stream checker: fill, verify, lock, and count errors
// with window-based loss-of-lock detection.
`timescale 1ns/1ps
module prng_checker
    import prng_checker_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = DEF_TAPS,
    parameter int               LOCK_CNT   = 16,
    parameter int               WINDOW     = 64,
    parameter int               ERR_THRESH = 8,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             lock_lost
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int WIN_W  = 16;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [7:0]        GOOD_LAST = 8'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0]  THR_LAST  = WIN_W'(ERR_THRESH - 1);

    logic [WIDTH-1:0] sr;
    logic             pred;
    logic             mismatch;
    logic             sr_zero;

    prng_lfsr_predict #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predict (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_in  (bit_in),
        .bit_vld (bit_vld),
        .sr      (sr),
        .pred    (pred)
    );

    assign mismatch = bit_vld & (bit_in != pred);
    assign sr_zero  = (sr == '0);

    state_e            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [7:0]        good_q, good_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WIN_W-1:0]  werr_q, werr_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic              lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    // Next-state logic: acquisition FSM, window error density and error counter.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        good_d      = good_q;
        win_d       = win_q;
        werr_d      = werr_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        lock_lost_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (bit_vld) begin
            case (state_q)
                SEARCH: begin
                    if (fill_q == FILL_LAST) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        good_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    // An all-zero history predicts zeros forever, so a stuck line never locks.
                    if (mismatch || sr_zero) begin
                        good_d = '0;
                    end else if (good_q == GOOD_LAST) begin
                        state_d  = LOCKED;
                        good_d   = '0;
                        win_d    = '0;
                        werr_d   = '0;
                        locked_d = 1'b1;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    // Threshold is judged before the window wraps on the same bit.
                    if (mismatch && (werr_q == THR_LAST)) begin
                        state_d     = SEARCH;
                        fill_d      = '0;
                        win_d       = '0;
                        werr_d      = '0;
                        locked_d    = 1'b0;
                        lock_lost_d = 1'b1;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + 1'b1;
                        werr_d = werr_q + {{(WIN_W-1){1'b0}}, mismatch};
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    fill_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            fill_q      <= '0;
            good_q      <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prng_checker.sv
// Testbench for prng_checker: directed vectors over a modelled PRNG stream.
`timescale 1ns/1ps
module tb_prng_checker;

    localparam logic [7:0] TB_TAPS = 8'b1011_1000;
    localparam logic [7:0] SEED    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_vld;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic        lock_lost;

    prng_checker #(
        .WIDTH      (8),
        .TAPS       (8'b1011_1000),
        .LOCK_CNT   (16),
        .WINDOW     (64),
        .ERR_THRESH (8),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .lock_lost (lock_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] g;

    typedef struct {
        string name;
        int    f0;          // first flipped bit (1-based index after lock), 0 = none
        int    f1;          // second flipped bit, 0 = none
        bit    clr0;        // assert clr_cnt together with the first flipped bit
        int    nbits;
        int    exp_pulses;
        int    exp_lost;
        int    exp_cnt;
        int    exp_locked;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference generator: next bit is the tap XOR of the previous eight bits.
    task automatic gen_bit(output logic b);
        b = ^(g & TB_TAPS);
        g = {g[6:0], b};
    endtask

    task automatic send(input logic b, input logic v, input logic c);
        @(negedge clk);
        bit_in  = b;
        bit_vld = v;
        clr_cnt = c;
        @(posedge clk);
        #1;
        bit_vld = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic do_reset(input bit check_state);
        bit_vld = 1'b0;
        clr_cnt = 1'b0;
        bit_in  = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (check_state) begin
            chk("reset_locked", int'(locked), 0);
            chk("reset_err_pulse", int'(err_pulse), 0);
            chk("reset_err_cnt", int'(err_cnt), 0);
            chk("reset_lock_lost", int'(lock_lost), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        g = SEED;
    endtask

    task automatic acquire(input string tag);
        logic b;
        for (int i = 1; i <= 24; i++) begin
            gen_bit(b);
            send(b, 1'b1, 1'b0);
            if (i == 23) chk({tag, "_locked_at23"}, int'(locked), 0);
            if (i == 24) chk({tag, "_locked_at24"}, int'(locked), 1);
        end
        chk({tag, "_cnt_after_lock"}, int'(err_cnt), 0);
    endtask

    initial begin
        logic b;
        logic line;
        logic fl;
        logic c;
        int   pulses;
        int   lost;
        int   ever;

        vecs[0] = '{"clean",       0,  0,  1'b0, 200, 0,  0, 0,  1};
        vecs[1] = '{"single",      10, 0,  1'b0, 40,  5,  0, 5,  1};
        vecs[2] = '{"two_lose",    10, 30, 1'b0, 40,  8,  1, 8,  0};
        vecs[3] = '{"win_split",   50, 60, 1'b0, 90,  10, 0, 10, 1};
        vecs[4] = '{"thr_at_wend", 50, 59, 1'b0, 80,  8,  1, 8,  0};
        vecs[5] = '{"clr_flip",    10, 0,  1'b1, 40,  5,  0, 4,  1};

        rst_n   = 1'b0;
        bit_in  = 1'b0;
        bit_vld = 1'b0;
        clr_cnt = 1'b0;
        g       = SEED;

        do_reset(1'b1);

        // Table-driven locked-state error scenarios.
        for (int v = 0; v < 6; v++) begin
            do_reset(1'b0);
            acquire(vecs[v].name);
            pulses = 0;
            lost   = 0;
            for (int i = 1; i <= vecs[v].nbits; i++) begin
                gen_bit(b);
                fl   = (i == vecs[v].f0) || (i == vecs[v].f1);
                c    = vecs[v].clr0 && (i == vecs[v].f0);
                line = b ^ fl;
                send(line, 1'b1, c);
                if (err_pulse) pulses++;
                if (lock_lost) lost++;
                if (c) begin
                    chk({vecs[v].name, "_clr_cnt"}, int'(err_cnt), 0);
                    chk({vecs[v].name, "_clr_pulse"}, int'(err_pulse), 1);
                end
            end
            chk({vecs[v].name, "_pulses"}, pulses, vecs[v].exp_pulses);
            chk({vecs[v].name, "_lost"}, lost, vecs[v].exp_lost);
            chk({vecs[v].name, "_err_cnt"}, int'(err_cnt), vecs[v].exp_cnt);
            chk({vecs[v].name, "_locked"}, int'(locked), vecs[v].exp_locked);
        end

        // Loss of lock followed by reacquisition exactly 24 valid bits later.
        do_reset(1'b0);
        acquire("relock");
        for (int i = 1; i <= 59; i++) begin
            gen_bit(b);
            line = b ^ ((i == 10) || (i == 30));
            send(line, 1'b1, 1'b0);
            if (i == 35) begin
                chk("relock_lost_pulse", int'(lock_lost), 1);
                chk("relock_locked_low", int'(locked), 0);
            end
            if (i == 36) chk("relock_lost_one_cycle", int'(lock_lost), 0);
            if (i == 58) chk("relock_at23", int'(locked), 0);
            if (i == 59) chk("relock_at24", int'(locked), 1);
        end
        chk("relock_err_cnt", int'(err_cnt), 8);

        // Stuck-at-0 and stuck-at-1 lines never lock.
        for (int s = 0; s < 2; s++) begin
            do_reset(1'b0);
            ever = 0;
            for (int i = 0; i < 100; i++) begin
                send(s[0], 1'b1, 1'b0);
                if (locked) ever = 1;
            end
            chk(s == 0 ? "stuck0_locked" : "stuck1_locked", ever, 0);
            chk(s == 0 ? "stuck0_err_cnt" : "stuck1_err_cnt", int'(err_cnt), 0);
        end

        // Invalid cycles interleaved with the stream are transparent.
        do_reset(1'b0);
        for (int i = 1; i <= 24; i++) begin
            gen_bit(b);
            send(b, 1'b1, 1'b0);
            if (i == 24) chk("gap_locked_at24", int'(locked), 1);
            send(1'($urandom()), 1'b0, 1'b0);
            if (i == 23) chk("gap_locked_at23", int'(locked), 0);
            if (i == 24) chk("gap_locked_hold", int'(locked), 1);
        end

        // Asynchronous reset while locked clears outputs immediately.
        do_reset(1'b0);
        acquire("areset");
        gen_bit(b);
        send(~b, 1'b1, 1'b0);
        chk("areset_pre_pulse", int'(err_pulse), 1);
        chk("areset_pre_cnt", int'(err_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_locked", int'(locked), 0);
        chk("areset_err_cnt", int'(err_cnt), 0);
        chk("areset_err_pulse", int'(err_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        g = SEED;
        acquire("areset_reacq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
